wb_pwm4: RTL

Four-channel Wishbone PWM generator that drives the quadcopter ESC/motor inputs. Sits on the LM32 data bus as a `conbus` slave, downstream of the CPU and interconnect, consuming register writes and producing four glitch-free PWM outputs. Duty values are double-buffered and applied only at period boundaries. A period-end interrupt lets firmware pace the control loop.

---
 rtl/wb_pwm_pkg.sv | 31 +++
 rtl/wb_pwm4_timebase.sv | 40 ++++
 rtl/wb_pwm4.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pwm_pkg.sv
// Shared definitions for the four-channel Wishbone PWM block.
package wb_pwm_pkg;

   typedef enum logic [2:0] {
      PWM_CTRL     = 3'd0,
      PWM_PRESCALE = 3'd1,
      PWM_PERIOD   = 3'd2,
      PWM_STATUS   = 3'd3,
      PWM_DUTY0    = 3'd4,
      PWM_DUTY1    = 3'd5,
      PWM_DUTY2    = 3'd6,
      PWM_DUTY3    = 3'd7
   } pwm_reg_e;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

   localparam logic [15:0] PERIOD_RST = 16'hFFFF;

   // Merge the two honoured byte lanes of a write into the current value.
   function automatic logic [15:0] be_merge(input logic [15:0] cur,
                                            input logic [15:0] wdat,
                                            input logic [1:0]  sel);
      logic [15:0] res;
      res = cur;
      if (sel[0]) res[7:0]  = wdat[7:0];
      if (sel[1]) res[15:8] = wdat[15:8];
      return res;
   endfunction

endpackage

// File: rtl/wb_pwm4_timebase.sv
// Prescaler and period counter; flags the tick on which the period wraps.
module pwm_timebase
   import wb_pwm_pkg::*;
#(
   parameter int unsigned cnt_w = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [cnt_w-1:0] prescale,
   input  logic [cnt_w-1:0] period,
   output logic [cnt_w-1:0] cnt,
   output logic             wrap
);

   logic [cnt_w-1:0] presc;
   logic             tick;

   // Compare with >= so a PRESCALE/PERIOD shrink below the running count
   // wraps on the next opportunity instead of running out to all-ones.
   always_comb begin
      tick = en && (presc >= prescale);
      wrap = tick && (cnt >= period);
   end

   // Prescaler and counter, both held at zero while disabled.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         presc <= '0;
         cnt   <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (wrap)
            cnt <= '0;
         else if (tick)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_pwm4.sv
// Four-channel Wishbone PWM generator with double-buffered duties and a
// period-end interrupt.
module wb_pwm4
   import wb_pwm_pkg::*;
#(
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned cnt_w    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        intr,
   output logic [3:0]  pwm_o
);

   pwm_reg_e         ofs;
   logic             acc;
   logic             wr;
   logic             clr;
   logic [31:0]      rdata;
   logic             en;
   logic             irq_en;
   logic             pend;
   logic [cnt_w-1:0] prescale;
   logic [cnt_w-1:0] period;
   logic [cnt_w-1:0] duty_sh  [4];
   logic [cnt_w-1:0] duty_act [4];
   logic [cnt_w-1:0] cnt;
   logic             wrap;
   logic [3:0]       pwm_nxt;
   logic             unused_bits;

   assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16],
                          wb_sel_i[3:2], clk_freq};

   pwm_timebase #(.cnt_w(cnt_w)) u_timebase (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .prescale (prescale),
      .period   (period),
      .cnt      (cnt),
      .wrap     (wrap)
   );

   // Bus decode, write-1-clear strobe and read mux.
   always_comb begin
      ofs   = pwm_reg_e'(wb_adr_i[4:2]);
      acc   = wb_stb_i && wb_cyc_i && !wb_ack_o;
      wr    = acc && wb_we_i;
      clr   = wr && (ofs == PWM_STATUS) && wb_sel_i[0] && wb_dat_i[0];
      rdata = '0;
      case (ofs)
         PWM_CTRL: begin
            rdata[CTRL_EN]     = en;
            rdata[CTRL_IRQ_EN] = irq_en;
         end
         PWM_PRESCALE: rdata = 32'(prescale);
         PWM_PERIOD:   rdata = 32'(period);
         PWM_STATUS:   rdata[0] = pend;
         default:      rdata = 32'(duty_sh[wb_adr_i[3:2]]);
      endcase
   end

   // Register file and bus handshake; writes commit as ack is raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         en       <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= '0;
         period   <= cnt_w'(PERIOD_RST);
         for (int unsigned i = 0; i < 4; i++) duty_sh[i] <= '0;
      end else begin
         wb_ack_o <= acc;
         if (acc) wb_dat_o <= rdata;
         if (wr) begin
            case (ofs)
               PWM_CTRL:
                  if (wb_sel_i[0]) begin
                     en     <= wb_dat_i[CTRL_EN];
                     irq_en <= wb_dat_i[CTRL_IRQ_EN];
                  end
               PWM_PRESCALE:
                  prescale <= cnt_w'(be_merge(16'(prescale), wb_dat_i[15:0], wb_sel_i[1:0]));
               PWM_PERIOD:
                  period <= cnt_w'(be_merge(16'(period), wb_dat_i[15:0], wb_sel_i[1:0]));
               PWM_DUTY0, PWM_DUTY1, PWM_DUTY2, PWM_DUTY3:
                  duty_sh[wb_adr_i[3:2]] <= cnt_w'(be_merge(16'(duty_sh[wb_adr_i[3:2]]),
                                                            wb_dat_i[15:0], wb_sel_i[1:0]));
               default: ;
            endcase
         end
      end
   end

   // Sticky period-end flag; a wrap beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset)
         pend <= 1'b0;
      else
         pend <= wrap || (pend && !clr);
   end

   // Active duties follow the shadows while idle, else reload only on wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++) duty_act[i] <= '0;
      end else if (!en || wrap) begin
         for (int unsigned i = 0; i < 4; i++) duty_act[i] <= duty_sh[i];
      end
   end

   // Per-channel compare against the shared counter.
   always_comb begin
      pwm_nxt = '0;
      for (int unsigned i = 0; i < 4; i++)
         pwm_nxt[i] = en && (cnt < duty_act[i]);
      intr = pend && irq_en;
   end

   // All channels registered together so they switch on the same edge.
   always_ff @(posedge clk) begin
      if (reset)
         pwm_o <= '0;
      else
         pwm_o <= pwm_nxt;
   end

endmodule
